serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Parallel-to-serial frame transmitter; the sending end of the single-bit serial link whose receive side samples the line with a clocked capture register.
- Accepts one DATA_W-bit word per valid/ready handshake.
- Drives an idle-high line: start bit (0), data LSB first, optional even-parity bit, stop bit (1).
- Each bit is held for CLKS_PER_BIT clocks. Sits between the course's datapath blocks and an FPGA output pin.

Parameters:
DATA_W, 8, payload width in bits (>=1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)
PARITY_EN, 0, 0 = no parity bit; 1 = even-parity bit inserted after MSB

Ports:
clk  input  1  system clock; all state changes on rising edge
Reset_n  input  1  asynchronous, active-low reset
tx_valid  input  1  tx_data holds a word to send
tx_data  input  DATA_W  word to transmit
tx_ready  output  1  block can accept a word this cycle
tx_out  output  1  serial line, registered, idle high
busy  output  1  frame in progress
done  output  1  one-cycle pulse in the final cycle of the stop bit

Behaviour:
- Reset and clocking: one clock (clk). Reset_n is asynchronous, active-low. While Reset_n=0: state=IDLE, tx_out=1, tx_ready=1, busy=0, done=0, counters=0, shift register=0. Values apply immediately, not at the next edge.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_ready=1, busy=0, tx_out=1.
  - Accept when tx_valid=1 and tx_ready=1 on a rising edge (acceptance cycle T).
  - At that edge: latch tx_data into the shift register, compute parity = XOR of all bits, go to START.
- START: tx_out=0 during cycles T+1..T+CLKS_PER_BIT.
- DATA: shift register LSB on tx_out. Each bit lasts CLKS_PER_BIT cycles; shift right at each bit boundary. After DATA_W bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx_out = XOR of latched data (even parity: total count of ones including this bit is even) for CLKS_PER_BIT cycles.
- STOP: tx_out=1 for CLKS_PER_BIT cycles. done=1 in the last of these cycles only. Next edge returns to IDLE.
- Outside IDLE: tx_ready=0, busy=1.
- Frame length F = (DATA_W+2+PARITY_EN)*CLKS_PER_BIT cycles, spanning T+1..T+F.
  - done asserts at T+F.
  - tx_ready=1 at T+F+1.
  - Earliest next acceptance is T+F+1, so exactly one idle-high cycle separates back-to-back frames.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; the bit boundary is at CLKS_PER_BIT-1. CLKS_PER_BIT=1 is legal: one cycle per bit, counter constant 0.
- Bit index: counts 0..DATA_W-1 in DATA, cleared on leaving DATA.
- tx_valid or tx_data changes while busy: ignored; the latched word is unaffected.
- Reset_n low mid-frame: line returns high immediately, frame abandoned, no done pulse. After release, IDLE with tx_ready=1.
- tx_valid=1 in the same cycle done=1: not accepted (tx_ready=0); accepted on the following edge if still asserted.
- tx_out is driven from a flop, never combinationally from state.

Test Plan:
- Reset: hold Reset_n=0 mid-cycle with clk stopped -> tx_out=1, tx_ready=1, busy=0, done=0 immediately.
- Defaults, send 0xA5 accepted at T:
  - tx_out=0 for T+1..T+4, then bits 1,0,1,0,0,1,0,1, each 4 cycles, then 1 for T+37..T+40.
  - done=1 only at T+40; tx_ready=1 at T+41.
- PARITY_EN=1, send 0x07:
  - parity bit=1 during T+37..T+40; stop T+41..T+44; done at T+44.
  - Send 0x03 -> parity bit=0.
- Send 0x3C; at T+10 drive tx_valid=1, tx_data=0xFF -> serial output still encodes 0x3C; 0xFF is accepted at T+41, its start bit at T+42..T+45.
- Send 0x55, assert Reset_n=0 during data bit 3 for 2 cycles -> tx_out=1 at once, no done pulse. After release tx_ready=1; next word 0x81 transmits correctly.
- CLKS_PER_BIT=1, tx_valid held high, words 0x00 then 0xFF -> frames of 10 cycles each, one idle-high cycle between them, two done pulses 11 cycles apart.

Source files
------------

// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
//   Parallel-to-serial frame transmitter for an idle-high single-bit link.
//   Each frame is a start bit (0), DATA_W data bits LSB first, an optional
//   even-parity bit and a stop bit (1). Every bit is held for CLKS_PER_BIT
//   clocks. One word is taken per valid/ready handshake.
//
// Parameters
//   DATA_W       payload width in bits (>= 1)
//   CLKS_PER_BIT clock cycles each serial bit is held (>= 1)
//   PARITY_EN    0 = no parity bit, 1 = even-parity bit after the MSB
//
// Ports
//   clk       system clock, all state changes on the rising edge
//   Reset_n   asynchronous active-low reset
//   tx_valid  tx_data holds a word to send
//   tx_data   word to transmit
//   tx_ready  block can accept a word this cycle
//   tx_out    serial line, registered, idle high
//   busy      frame in progress
//   done      one-cycle pulse in the final cycle of the stop bit
// -----------------------------------------------------------------------------
module serial_frame_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 0
) (
   input  logic              clk,
   input  logic              Reset_n,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              busy,
   output logic              done
);

   // A one-bit counter is kept even when it can only ever hold zero.
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  baud_cnt;
   logic [IDX_W-1:0]  bit_idx;
   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W-1:0] shift_next;
   logic              parity_bit;
   logic              tx_out_next;
   logic              bit_end;
   logic              accept;

   assign bit_end = (baud_cnt == BAUD_LAST);
   assign accept  = tx_valid && tx_ready;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential blocks use non-blocking assignments only, so every flop
   // samples the values from before the edge regardless of statement order.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every signal assigned in a combinational block gets a default at the
   // top, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)  state_next = START;
         START:   if (bit_end) state_next = DATA;
         DATA: begin
            if (bit_end && (bit_idx == IDX_LAST)) begin
               state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY:  if (bit_end) state_next = STOP;
         STOP:    if (bit_end) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic
   // -------------------------------------------------------------------------
   // tx_out_next is the line level for the coming cycle; it is derived from
   // the next state and next shift contents so the line flop changes on the
   // same edge as the state it belongs to.
   always_comb begin
      tx_ready    = (state == IDLE);
      busy        = (state != IDLE);
      done        = (state == STOP) && bit_end;

      shift_next  = shift_reg;
      if (accept) begin
         shift_next = tx_data;
      end else if ((state == DATA) && bit_end) begin
         shift_next = shift_reg >> 1;
      end

      tx_out_next = 1'b1;
      case (state_next)
         IDLE:    tx_out_next = 1'b1;
         START:   tx_out_next = 1'b0;
         DATA:    tx_out_next = shift_next[0];
         PARITY:  tx_out_next = parity_bit;
         STOP:    tx_out_next = 1'b1;
         default: tx_out_next = 1'b1;
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath registers: baud counter, bit index, shift register, parity, line
   // -------------------------------------------------------------------------
   // NOTE: all datapath flops are in the async reset; the line flop resets to
   // 1 so an abandoned frame returns the link to idle without waiting a clock.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         tx_out     <= 1'b1;
      end else begin
         if (state == IDLE) begin
            baud_cnt <= '0;
         end else begin
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
         end

         if (state != DATA) begin
            bit_idx <= '0;
         end else if (bit_end) begin
            bit_idx <= (bit_idx == IDX_LAST) ? '0 : bit_idx + 1'b1;
         end

         if (accept) begin
            parity_bit <= ^tx_data;
         end

         shift_reg <= shift_next;
         tx_out    <= tx_out_next;
      end
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_tx
//   Self-checking bench for serial_frame_tx. Three instances cover the default
//   configuration, PARITY_EN=1 and CLKS_PER_BIT=1. When a word is driven, the
//   expected per-cycle line/done/ready/busy values of its frame are pushed to a
//   scoreboard queue; each following cycle pops one entry and compares it with
//   the selected instance.
// -----------------------------------------------------------------------------
module tb_serial_frame_tx;

   typedef struct packed {
      logic line;
      logic done;
      logic ready;
      logic busy;
   } exp_t;

   localparam int N_DUT = 3;
   localparam int CPB [N_DUT] = '{4, 4, 1};
   localparam int PAR [N_DUT] = '{0, 1, 0};

   logic       clk     = 1'b0;
   logic       clk_run = 1'b0;
   logic       Reset_n = 1'b1;
   logic       tx_valid [N_DUT];
   logic [7:0] tx_data  [N_DUT];
   logic       tx_ready [N_DUT];
   logic       tx_out   [N_DUT];
   logic       busy     [N_DUT];
   logic       done     [N_DUT];

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Clock can be stopped to observe the asynchronous reset in isolation.
   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_def (
      .clk(clk), .Reset_n(Reset_n), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
      .tx_ready(tx_ready[0]), .tx_out(tx_out[0]), .busy(busy[0]), .done(done[0])
   );

   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_par (
      .clk(clk), .Reset_n(Reset_n), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
      .tx_ready(tx_ready[1]), .tx_out(tx_out[1]), .busy(busy[1]), .done(done[1])
   );

   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_fast (
      .clk(clk), .Reset_n(Reset_n), .tx_valid(tx_valid[2]), .tx_data(tx_data[2]),
      .tx_ready(tx_ready[2]), .tx_out(tx_out[2]), .busy(busy[2]), .done(done[2])
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_dut(input int i, input string tag, input exp_t e);
      check($sformatf("%s.line", tag),  {7'd0, tx_out[i]},   {7'd0, e.line});
      check($sformatf("%s.done", tag),  {7'd0, done[i]},     {7'd0, e.done});
      check($sformatf("%s.ready", tag), {7'd0, tx_ready[i]}, {7'd0, e.ready});
      check($sformatf("%s.busy", tag),  {7'd0, busy[i]},     {7'd0, e.busy});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int frame_len(input int i);
      return (10 + PAR[i]) * CPB[i];
   endfunction

   // Expected cycles T+1..T+F of one frame.
   task automatic push_frame(input int i, input logic [7:0] d);
      int   nb;
      logic b;
      nb = 10 + PAR[i];
      for (int k = 0; k < nb; k++) begin
         if (k == 0)                    b = 1'b0;
         else if (k <= 8)               b = d[k-1];
         else if (PAR[i] != 0 && k == 9) b = ^d;
         else                           b = 1'b1;
         for (int c = 0; c < CPB[i]; c++) begin
            sb_q.push_back('{line: b, done: (k == nb - 1) && (c == CPB[i] - 1),
                             ready: 1'b0, busy: 1'b1});
         end
      end
   endtask

   task automatic push_idle(input int n);
      for (int k = 0; k < n; k++) begin
         sb_q.push_back('{line: 1'b1, done: 1'b0, ready: 1'b1, busy: 1'b0});
      end
   endtask

   // Advance n cycles, comparing instance i against the scoreboard each cycle.
   task automatic run(input int i, input int n, input string tag);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         tick();
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=empty scoreboard expected=entry", tag);
         end else begin
            e = sb_q.pop_front();
            check_dut(i, tag, e);
         end
      end
   endtask

   // Full handshake at the current cycle T, checked through T+F+1.
   task automatic send(input int i, input logic [7:0] d, input string tag);
      check($sformatf("%s.ready_pre", tag), {7'd0, tx_ready[i]}, 8'd1);
      tx_valid[i] = 1'b1;
      tx_data[i]  = d;
      push_frame(i, d);
      run(i, 1, tag);
      tx_valid[i] = 1'b0;
      run(i, frame_len(i) - 1, tag);
      push_idle(1);
      run(i, 1, tag);
   endtask

   task automatic check_idle_all(input string tag);
      for (int i = 0; i < N_DUT; i++) begin
         check_dut(i, $sformatf("%s%0d", tag, i),
                   '{line: 1'b1, done: 1'b0, ready: 1'b1, busy: 1'b0});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      for (int i = 0; i < N_DUT; i++) begin
         tx_valid[i] = 1'b0;
         tx_data[i]  = 8'h00;
      end

      // Asynchronous reset with the clock stopped.
      #3 Reset_n = 1'b0;
      #2 check_idle_all("reset_async");
      #5 Reset_n = 1'b1;
      clk_run = 1'b1;
      tick();
      check_idle_all("after_reset");

      // Defaults: 0xA5.
      send(0, 8'hA5, "def_a5");

      // Even parity: 0x07 -> 1, 0x03 -> 0.
      send(1, 8'h07, "par_07");
      send(1, 8'h03, "par_03");

      // 0x3C with 0xFF presented while busy; 0xFF must wait for T+41.
      check("busy_in.ready_pre", {7'd0, tx_ready[0]}, 8'd1);
      tx_valid[0] = 1'b1;
      tx_data[0]  = 8'h3C;
      push_frame(0, 8'h3C);
      run(0, 1, "busy_in_3c");
      tx_valid[0] = 1'b0;
      run(0, 9, "busy_in_3c");
      tx_valid[0] = 1'b1;
      tx_data[0]  = 8'hFF;
      run(0, 30, "busy_in_3c");
      push_idle(1);
      run(0, 1, "busy_in_gap");
      push_frame(0, 8'hFF);
      run(0, 1, "busy_in_ff");
      tx_valid[0] = 1'b0;
      run(0, frame_len(0) - 1, "busy_in_ff");
      push_idle(1);
      run(0, 1, "busy_in_ff");

      // Reset during data bit 3 of 0x55.
      check("abort.ready_pre", {7'd0, tx_ready[0]}, 8'd1);
      tx_valid[0] = 1'b1;
      tx_data[0]  = 8'h55;
      push_frame(0, 8'h55);
      run(0, 1, "abort_55");
      tx_valid[0] = 1'b0;
      run(0, 16, "abort_55");
      sb_q.delete();
      Reset_n = 1'b0;
      #1 check_idle_all("abort_now");
      tick();
      check_idle_all("abort_hold_a");
      tick();
      check_idle_all("abort_hold_b");
      Reset_n = 1'b1;
      #1 check_idle_all("abort_release");
      send(0, 8'h81, "after_abort_81");

      // CLKS_PER_BIT=1, valid held high across 0x00 then 0xFF.
      check("fast.ready_pre", {7'd0, tx_ready[2]}, 8'd1);
      tx_valid[2] = 1'b1;
      tx_data[2]  = 8'h00;
      push_frame(2, 8'h00);
      run(2, frame_len(2), "fast_00");
      tx_data[2] = 8'hFF;
      push_idle(1);
      run(2, 1, "fast_gap");
      push_frame(2, 8'hFF);
      run(2, 1, "fast_ff");
      tx_valid[2] = 1'b0;
      run(2, frame_len(2) - 1, "fast_ff");
      push_idle(1);
      run(2, 1, "fast_ff");

      check("scoreboard_drained", 8'(sb_q.size()), 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
